// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial subtraction controller.
// The requester drives the operands and start; the controller returns busy/done/diff/bout.
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell stepped LSB-first,
// one bit per clock, with a one-cycle done pulse when diff/bout are valid.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one operand bit per cycle through the cell, LSB first
// DONE  | diff/bout valid, done pulses for this single cycle
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_ctrl_if.slave sub
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             d;
  logic             bo;
  logic             last;
  logic [WIDTH-1:0] diff_shift;

  // Full-subtractor cell
  assign d    = a_sh[0] ^ b_sh[0] ^ brw;
  assign bo   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
  assign last = (cnt == CW'(WIDTH - 1));

  // A one-bit result has nothing to shift down, so it is just the cell output.
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_shift = d;
    end else begin : g_wn
      assign diff_shift = {d, diff_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (sub.start) begin
            a_sh   <= sub.a;
            b_sh   <= sub.b;
            brw    <= sub.bin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          diff_q <= diff_shift;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          brw    <= bo;
          cnt    <= cnt + CW'(1);
          if (last) begin
            bout_q <= bo;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign sub.busy = busy_q;
  assign sub.done = done_q;
  assign sub.diff = diff_q;
  assign sub.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench: drivers push expected results, negedge monitors pop and compare on done.
module tb_serial_subtractor_ctrl;

  localparam int W8 = 8;
  localparam int W2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_ctrl_if #(.WIDTH(W8)) i8 ();
  serial_subtractor_ctrl_if #(.WIDTH(W2)) i2 ();

  serial_subtractor_ctrl #(.WIDTH(W8)) dut8 (.clk(clk), .rst_n(rst_n), .sub(i8.slave));
  serial_subtractor_ctrl #(.WIDTH(W2)) dut2 (.clk(clk), .rst_n(rst_n), .sub(i2.slave));

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    int         due;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endfunction

  // Plain-arithmetic reference: modular difference and borrow as a comparison.
  function automatic exp_t model(int w, int a, int b, int bin, int due);
    exp_t e;
    int   m;
    int   dv;
    m      = 1 << w;
    dv     = ((a - b - bin) % m + m) % m;
    e.diff = 8'(dv);
    e.bout = (a < b + bin);
    e.due  = due;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && i8.done) begin
      if (q8.size() == 0) begin
        total++;
        $display("FAIL w8_unexpected_done actual=done required=no_done (t=%0t)", $time);
      end else begin
        e = q8.pop_front();
        chk("w8_diff", 32'(i8.diff), 32'(e.diff));
        chk("w8_bout", 32'(i8.bout), 32'(e.bout));
        chk("w8_latency", cyc, e.due);
        chk("w8_busy_at_done", 32'(i8.busy), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && i2.done) begin
      if (q2.size() == 0) begin
        total++;
        $display("FAIL w2_unexpected_done actual=done required=no_done (t=%0t)", $time);
      end else begin
        e = q2.pop_front();
        chk("w2_diff", 32'(i2.diff), 32'(e.diff[1:0]));
        chk("w2_bout", 32'(i2.bout), 32'(e.bout));
        chk("w2_latency", cyc, e.due);
      end
    end
  end

  // Issue one start from IDLE, then wait (bounded) for its done; also counts busy cycles.
  task automatic op8(input int a, input int b, input int bin);
    int n;
    int bc;
    @(negedge clk);
    i8.a = 8'(a); i8.b = 8'(b); i8.bin = 1'(bin); i8.start = 1'b1;
    q8.push_back(model(W8, a, b, bin, cyc + 1 + W8));
    @(negedge clk);
    i8.start = 1'b0;
    i8.a = 8'($urandom); i8.b = 8'($urandom); i8.bin = 1'($urandom);
    n = 0; bc = 0;
    while (1) begin
      if (i8.busy) bc++;
      if (i8.done) break;
      if (n >= W8 + 4) begin
        total++;
        $display("FAIL w8_timeout actual=no_done required=done (t=%0t)", $time);
        break;
      end
      @(negedge clk);
      n++;
    end
    chk("w8_busy_cycles", bc, W8 + 1);
    @(negedge clk);
  endtask

  task automatic op2(input int a, input int b, input int bin);
    int n;
    @(negedge clk);
    i2.a = 2'(a); i2.b = 2'(b); i2.bin = 1'(bin); i2.start = 1'b1;
    q2.push_back(model(W2, a, b, bin, cyc + 1 + W2));
    @(negedge clk);
    i2.start = 1'b0;
    n = 0;
    while (!i2.done) begin
      if (n >= W2 + 4) begin
        total++;
        $display("FAIL w2_timeout actual=no_done required=done (t=%0t)", $time);
        break;
      end
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    int dones;
    int k;
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.bin = 1'b0;
    i2.start = 1'b0; i2.a = '0; i2.b = '0; i2.bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(i8.busy), 32'd0);
    chk("rst_done", 32'(i8.done), 32'd0);
    chk("rst_diff", 32'(i8.diff), 32'd0);
    chk("rst_bout", 32'(i8.bout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'h5A, 8'h3C, 0);
    op8(8'h00, 8'h01, 0);
    op8(8'h10, 8'h0F, 1);

    // Start re-asserted in SHIFT cycle 3 and in DONE must be ignored.
    @(negedge clk);
    i8.a = 8'h80; i8.b = 8'h01; i8.bin = 1'b0; i8.start = 1'b1;
    q8.push_back(model(W8, 8'h80, 8'h01, 0, cyc + 1 + W8));
    @(negedge clk);
    i8.start = 1'b0;
    repeat (2) @(negedge clk);
    i8.a = 8'hFF; i8.b = 8'hFF; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    n = 0;
    while (!i8.done && n < W8 + 4) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_done_seen", 32'(i8.done), 32'd1);
    i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    chk("ignore_busy_after_done", 32'(i8.busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("ignore_still_idle", 32'(i8.busy), 32'd0);
    op8(8'h12, 8'h34, 0);

    // Reset in SHIFT cycle 4 abandons the operation.
    @(negedge clk);
    i8.a = 8'h5A; i8.b = 8'h11; i8.bin = 1'b0; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(i8.busy), 32'd0);
    chk("midrst_done", 32'(i8.done), 32'd0);
    chk("midrst_diff", 32'(i8.diff), 32'd0);
    chk("midrst_bout", 32'(i8.bout), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (W8 + 2) @(negedge clk);
    chk("midrst_no_done_q", q8.size(), 0);
    op8(8'h03, 8'h05, 0);

    // Start held high: one operation every WIDTH+2 cycles.
    @(negedge clk);
    i8.a = 8'h0A; i8.b = 8'h03; i8.bin = 1'b0; i8.start = 1'b1;
    k = cyc;
    for (int i = 0; i < 3; i++) q8.push_back(model(W8, 8'h0A, 8'h03, 0, k + 1 + W8 + i * (W8 + 2)));
    dones = 0; n = 0;
    while (dones < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (i8.done) dones++;
    end
    i8.start = 1'b0;
    chk("b2b_done_count", dones, 3);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 30; i++) op8(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));

    for (int v = 0; v < 32; v++) op2(v & 3, (v >> 2) & 3, (v >> 4) & 1);

    repeat (4) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
